// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: drives the word-wide data memory for byte/half/word
// accesses, splitting misaligned ones into two word accesses and extending load data.
module load_store_unit #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_WAIT, S_RESP} state_t;

    state_t        r_state, w_next;
    logic          r_we, r_split;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic [AW-1:0] r_word;
    logic [31:0]   r_wdata, r_first;

    logic          r_mem_re, r_mem_we, r_resp_valid, r_resp_err;
    logic [3:0]    r_mem_be;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata, r_resp_rdata;

    logic          w_mem_re, w_mem_we, w_resp_valid, w_resp_err;
    logic [3:0]    w_mem_be;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata, w_resp_rdata;

    logic          w_ready, w_accept, w_legal, w_split_req;
    logic [2:0]    w_src_f3;
    logic [1:0]    w_src_off;
    logic [31:0]   w_src_wdata;
    logic [3:0]    w_mask;
    logic [7:0]    w_be8;
    logic [63:0]   w_wd64, w_cat, w_shr;
    logic [31:0]   w_load;
    logic          w_unused;

    assign w_unused = ^req_addr[31:AW+2];

    assign w_ready   = (r_state == S_IDLE) && !rst;
    assign req_ready = w_ready;
    assign w_accept  = req_valid && w_ready;

    assign w_legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                            : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_split_req = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                         ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11));

    // Lane steering shared by both accesses: low half feeds the first word, high half the second
    assign w_src_f3    = (r_state == S_IDLE) ? req_funct3     : r_f3;
    assign w_src_off   = (r_state == S_IDLE) ? req_addr[1:0]  : r_off;
    assign w_src_wdata = (r_state == S_IDLE) ? req_wdata      : r_wdata;

    always_comb begin
        w_mask = 4'b1111;
        case (w_src_f3[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_be8  = {4'b0000, w_mask} << w_src_off;
    assign w_wd64 = {32'h0, w_src_wdata} << {w_src_off, 3'b000};

    // Load merge: {second, first} for split accesses, then align and extend
    assign w_cat = r_split ? {mem_rdata, r_first} : {32'h0, mem_rdata};
    assign w_shr = w_cat >> {r_off, 3'b000};

    always_comb begin
        w_load = w_shr[31:0];
        case (r_f3)
            3'b000:  w_load = {{24{w_shr[7]}},  w_shr[7:0]};
            3'b001:  w_load = {{16{w_shr[15]}}, w_shr[15:0]};
            3'b100:  w_load = {24'h0, w_shr[7:0]};
            3'b101:  w_load = {16'h0, w_shr[15:0]};
            default: w_load = w_shr[31:0];
        endcase
    end

    // Next state and next values of the registered outputs
    always_comb begin
        w_next       = r_state;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_be     = 4'b0000;
        w_mem_addr   = '0;
        w_mem_wdata  = 32'h0;
        w_resp_valid = 1'b0;
        w_resp_err   = 1'b0;
        w_resp_rdata = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_next       = S_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_err   = 1'b1;
                    end else begin
                        w_next     = S_ACC1;
                        w_mem_addr = req_addr[AW+1:2];
                        w_mem_re   = !req_we;
                        w_mem_we   = req_we;
                        if (req_we) begin
                            w_mem_be    = w_be8[3:0];
                            w_mem_wdata = w_wd64[31:0];
                        end
                    end
                end
            end
            S_ACC1: begin
                if (r_split) begin
                    w_next     = S_ACC2;
                    w_mem_addr = r_word + AW'(1);
                    w_mem_re   = !r_we;
                    w_mem_we   = r_we;
                    if (r_we) begin
                        w_mem_be    = w_be8[7:4];
                        w_mem_wdata = w_wd64[63:32];
                    end
                end else if (r_we) begin
                    w_next       = S_RESP;
                    w_resp_valid = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_ACC2: begin
                if (r_we) begin
                    w_next       = S_RESP;
                    w_resp_valid = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next       = S_RESP;
                w_resp_valid = 1'b1;
                w_resp_rdata = w_load;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_split      <= 1'b0;
            r_f3         <= 3'b000;
            r_off        <= 2'b00;
            r_word       <= '0;
            r_wdata      <= 32'h0;
            r_first      <= 32'h0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'b0000;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_state      <= w_next;
            r_mem_re     <= w_mem_re;
            r_mem_we     <= w_mem_we;
            r_mem_be     <= w_mem_be;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_resp_valid <= w_resp_valid;
            r_resp_err   <= w_resp_err;
            r_resp_rdata <= w_resp_rdata;
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_off   <= req_addr[1:0];
                r_word  <= req_addr[AW+1:2];
                r_wdata <= req_wdata;
                r_split <= w_split_req;
            end
            // First read word is on mem_rdata during ACC2
            if (r_state == S_ACC2) begin
                r_first <= mem_rdata;
            end
        end
    end

    assign mem_re     = r_mem_re;
    assign mem_we     = r_mem_we;
    assign mem_be     = r_mem_be;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule
